hazard_forward_unit_r1: RTL and testbench
=========================================

Name: hazard_forward_unit_r1

Overview:
- Combined hazard-detection and forwarding controller for the 5-stage MIPS pipeline; next generation of the standalone forwarding unit.
- Keeps its own scoreboard of in-flight writers across the EX, MEM and WB slots, advanced by its own stall/bubble decisions.
- Produces per-operand forward selects for an arbitrary number of read ports, load-use and ID-branch stalls, IF/ID flush, multi-cycle EX hold, and a saturating stall counter.

Parameters:
- REG_ADDR_WIDTH, 5, register address width.
- RD_PORTS, 2, number of source operands per instruction (rs, rt, ...).
- CNT_WIDTH, 16, width of the stall performance counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- id_src  in  RD_PORTS*REG_ADDR_WIDTH  packed ID source registers, port 0 in the LSBs.
- id_src_used  in  RD_PORTS  bit i set = port i is actually read.
- id_valid  in  1  ID holds a real (non-flushed) instruction.
- id_regWrite  in  1  ID instruction writes a register.
- id_regToWrite  in  REG_ADDR_WIDTH  ID destination register.
- id_memRead  in  1  ID instruction is a load.
- id_branch  in  1  ID instruction is a conditional branch or jr, and so compares or reads registers in ID.
- id_redirect  in  1  ID resolves a taken branch, jump, jal or jr.
- ex_busy  in  1  multi-cycle EX operation not yet done.
- stall  out  1  hold PC and IF/ID.
- bubble_ex  out  1  load a NOP into ID/EX.
- flush_id  out  1  zero the IF/ID instruction next cycle.
- hold_ex  out  1  hold ID/EX; a bubble goes to MEM.
- forward_sel  out  RD_PORTS*2  packed EX operand selects: 0 = regfile, 1 = MEM, 2 = WB.
- stall_count  out  CNT_WIDTH  saturating count of stall cycles.

Behaviour:
- State: three slots (EX, MEM, WB), each holding {valid, regWrite, dest, isLoad}, plus per-port EX source registers and used bits. All are cleared asynchronously when rst = 0.
- Reset values: every output is 0.
- Writer match: a slot "writes r" when valid && regWrite && dest == r && r != 0. Register 0 never matches.
- Load-use hazard: any used ID source is written by an EX slot with isLoad.
- Branch hazard: id_branch, and any used ID source is written by the EX slot or the MEM slot.
- stall is combinational: (id_valid && (load-use || branch hazard)) || ex_busy.
- bubble_ex = stall && !ex_busy.
- hold_ex = ex_busy.
- flush_id = id_redirect && !stall. A redirect seen during a stall is ignored; ID re-presents it after the stall.
- Slot advance on each clock edge:
  - ex_busy: EX slot holds, MEM receives invalid, WB <= MEM.
  - bubble_ex: EX receives invalid, MEM <= EX, WB <= MEM.
  - Otherwise: EX <= ID fields (valid = id_valid), MEM <= EX, WB <= MEM.
- forward_sel[i] is combinational from the EX source port i:
  - 1 if MEM writes it; else 2 if WB writes it; else 0.
  - MEM has priority over WB.
  - An unused port gives 0.
- stall_count increments on every cycle with stall = 1 and saturates at all-ones.
- Latency:
  - Hazard outputs are valid in the same cycle as the ID inputs.
  - Forward selects apply to the instruction one cycle after it leaves ID.
- Reset mid-stall: all slots are invalidated, so no stale forward is possible after reset is released.

Optional Feature:
- Macro: ID_BRANCH_FWD_EN.
- Defined:
  - Adds output id_forward_sel (RD_PORTS bits; 1 = take the MEM ALU result for the ID compare).
  - A branch hazard then stalls only on EX-slot producers, or on MEM-slot producers with isLoad.
  - MEM non-load producers are forwarded instead of stalled.
- Undefined: the port is absent and branches stall on any EX or MEM producer, as above.

Decomposition:
- Shared package hazard_pkg:
  - constants FWD_REG = 2'd0, FWD_MEM = 2'd1, FWD_WB = 2'd2;
  - slot field widths and the slot bit-packing layout;
  - the REG0 constant.
- Sub-module hazard_slot_r1: one scoreboard entry with load, hold and bubble controls and async active-low clear. It is instantiated three times.

Test Plan:
- lw $2 then add $3,$2,$4 back-to-back:
  - stall = 1 and bubble_ex = 1 for exactly one cycle;
  - next cycle forward_sel port0 = 2 (WB);
  - stall_count = 1.
- add $2 then sub $5,$2,$2: no stall; forward_sel = {1,1} (MEM on both ports).
- add $2 then or $6,$2,$7 one instruction apart: forward_sel port0 = 2.
- Writer to $0 followed by a reader of $0: forward_sel = 0, no stall.
- beq $2,$3 immediately after add $2:
  - without ID_BRANCH_FWD_EN: stall for 2 cycles, then flush_id = 1 if taken;
  - with ID_BRANCH_FWD_EN: 1 stall cycle, then id_forward_sel port0 = 1.
- ex_busy held 3 cycles with id_redirect = 1:
  - stall = 1, hold_ex = 1, flush_id = 0 throughout, MEM slot invalid;
  - flush_id = 1 on the first cycle after busy drops;
  - rst pulsed low mid-stall: all outputs and stall_count = 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants for the hazard/forwarding unit: forward select encodings,
// scoreboard slot bit layout and the hard-wired zero register.
package hazard_pkg;

   localparam logic [1:0] FWD_REG = 2'd0;
   localparam logic [1:0] FWD_MEM = 2'd1;
   localparam logic [1:0] FWD_WB  = 2'd2;

   // Slot layout, LSB first: valid, regWrite, isLoad, then dest register.
   localparam int unsigned SLOT_VALID    = 0;
   localparam int unsigned SLOT_WE       = 1;
   localparam int unsigned SLOT_LD       = 2;
   localparam int unsigned SLOT_DEST_LSB = 3;
   localparam int unsigned SLOT_META_W   = 3;

   localparam int unsigned REG0 = 0;

   function automatic int unsigned slot_width(input int unsigned addr_w);
      return addr_w + SLOT_META_W;
   endfunction

endpackage

// File: rtl/hazard_slot_r1.sv
// One scoreboard entry: hold keeps the entry, bubble invalidates it, load
// captures d_i. Cleared asynchronously by active-low rst_n.
module hazard_slot_r1 #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic         hold_i,
   input  logic         bubble_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] slot_q, slot_d;

   always_comb begin
      slot_d = slot_q;
      if (hold_i)
         slot_d = slot_q;
      else if (bubble_i)
         slot_d = '0;
      else if (load_i)
         slot_d = d_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         slot_q <= '0;
      else
         slot_q <= slot_d;
   end

   assign q_o = slot_q;

endmodule

// File: rtl/hazard_forward_unit_r1.sv
// Hazard detection and EX forwarding for the 5-stage MIPS pipeline, tracking
// in-flight writers in EX/MEM/WB slots. Define ID_BRANCH_FWD_EN for ID-branch forwarding.
module hazard_forward_unit_r1
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned RD_PORTS       = 2,
   parameter int unsigned CNT_WIDTH      = 16
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [RD_PORTS*REG_ADDR_WIDTH-1:0] id_src,
   input  logic [RD_PORTS-1:0]                id_src_used,
   input  logic                               id_valid,
   input  logic                               id_regWrite,
   input  logic [REG_ADDR_WIDTH-1:0]          id_regToWrite,
   input  logic                               id_memRead,
   input  logic                               id_branch,
   input  logic                               id_redirect,
   input  logic                               ex_busy,
   output logic                               stall,
   output logic                               bubble_ex,
   output logic                               flush_id,
   output logic                               hold_ex,
   output logic [RD_PORTS*2-1:0]              forward_sel,
`ifdef ID_BRANCH_FWD_EN
   output logic [RD_PORTS-1:0]                id_forward_sel,
`endif
   output logic [CNT_WIDTH-1:0]               stall_count
);

   localparam int unsigned SW = slot_width(REG_ADDR_WIDTH);

   logic [SW-1:0] id_slot, ex_slot_q, mem_slot_q, wb_slot_q;
   logic [RD_PORTS*REG_ADDR_WIDTH-1:0] ex_src_q, ex_src_d;
   logic [RD_PORTS-1:0]                ex_used_q, ex_used_d;
   logic [CNT_WIDTH-1:0]               stall_cnt_q, stall_cnt_d;
   logic                               load_use, br_haz;
   logic [RD_PORTS*2-1:0]              fwd;
   logic [RD_PORTS-1:0]                id_fwd;
   logic                               unused_bits;

   function automatic logic writes(input logic [SW-1:0] s,
                                   input logic [REG_ADDR_WIDTH-1:0] r);
      return s[SLOT_VALID] && s[SLOT_WE] &&
             (s[SLOT_DEST_LSB +: REG_ADDR_WIDTH] == r) &&
             (r != REG_ADDR_WIDTH'(REG0));
   endfunction

   always_comb begin
      id_slot = '0;
      id_slot[SLOT_VALID] = id_valid;
      id_slot[SLOT_WE]    = id_regWrite;
      id_slot[SLOT_LD]    = id_memRead;
      id_slot[SLOT_DEST_LSB +: REG_ADDR_WIDTH] = id_regToWrite;
   end

   hazard_slot_r1 #(.W(SW)) u_slot_ex (
      .clk(clk), .rst_n(rst), .load_i(1'b1), .hold_i(ex_busy),
      .bubble_i(bubble_ex), .d_i(id_slot), .q_o(ex_slot_q)
   );

   hazard_slot_r1 #(.W(SW)) u_slot_mem (
      .clk(clk), .rst_n(rst), .load_i(1'b1), .hold_i(1'b0),
      .bubble_i(ex_busy), .d_i(ex_slot_q), .q_o(mem_slot_q)
   );

   hazard_slot_r1 #(.W(SW)) u_slot_wb (
      .clk(clk), .rst_n(rst), .load_i(1'b1), .hold_i(1'b0),
      .bubble_i(1'b0), .d_i(mem_slot_q), .q_o(wb_slot_q)
   );

   always_comb begin
      load_use = 1'b0;
      br_haz   = 1'b0;
      fwd      = '0;
      id_fwd   = '0;
      for (int unsigned i = 0; i < RD_PORTS; i++) begin
         if (id_src_used[i]) begin
            if (writes(ex_slot_q, id_src[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]) &&
                ex_slot_q[SLOT_LD])
               load_use = 1'b1;
`ifdef ID_BRANCH_FWD_EN
            // MEM ALU results reach the ID comparator; only MEM loads still stall.
            if (writes(ex_slot_q, id_src[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]) ||
                (writes(mem_slot_q, id_src[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]) &&
                 mem_slot_q[SLOT_LD]))
               br_haz = 1'b1;
            if (writes(mem_slot_q, id_src[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]) &&
                !mem_slot_q[SLOT_LD])
               id_fwd[i] = id_branch;
`else
            if (writes(ex_slot_q, id_src[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]) ||
                writes(mem_slot_q, id_src[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]))
               br_haz = 1'b1;
`endif
         end
         fwd[i*2 +: 2] = FWD_REG;
         if (ex_used_q[i]) begin
            if (writes(mem_slot_q, ex_src_q[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]))
               fwd[i*2 +: 2] = FWD_MEM;
            else if (writes(wb_slot_q, ex_src_q[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]))
               fwd[i*2 +: 2] = FWD_WB;
         end
      end
      br_haz = br_haz && id_branch;
   end

   assign stall       = (id_valid && (load_use || br_haz)) || ex_busy;
   assign bubble_ex   = stall && !ex_busy;
   assign hold_ex     = ex_busy;
   assign flush_id    = id_redirect && !stall;
   assign forward_sel = fwd;
`ifdef ID_BRANCH_FWD_EN
   assign id_forward_sel = id_fwd;
   assign unused_bits    = ^{wb_slot_q[SLOT_LD]};
`else
   assign unused_bits    = ^{wb_slot_q[SLOT_LD], mem_slot_q[SLOT_LD], id_fwd};
`endif

   // EX source registers follow the EX slot: hold on busy, cleared on bubble.
   always_comb begin
      ex_src_d  = ex_src_q;
      ex_used_d = ex_used_q;
      if (ex_busy) begin
         ex_src_d  = ex_src_q;
         ex_used_d = ex_used_q;
      end else if (bubble_ex) begin
         ex_used_d = '0;
      end else begin
         ex_src_d  = id_src;
         ex_used_d = id_src_used;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_src_q    <= '0;
         ex_used_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         ex_src_q    <= ex_src_d;
         ex_used_q   <= ex_used_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit_r1.sv
// Directed bench for hazard_forward_unit_r1 with a second narrow-counter
// instance for saturation.
module tb_hazard_forward_unit_r1;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  id_src;
   logic [1:0]  id_src_used;
   logic        id_valid, id_regWrite, id_memRead, id_branch, id_redirect, ex_busy;
   logic [4:0]  id_regToWrite;

   logic        stall, bubble_ex, flush_id, hold_ex;
   logic [3:0]  forward_sel;
   logic [15:0] stall_count;
   logic        stall_s, bubble_s, flush_s, hold_s;
   logic [3:0]  fwd_s;
   logic [3:0]  count_s;
`ifdef ID_BRANCH_FWD_EN
   logic [1:0]  id_forward_sel, id_fwd_s;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hazard_forward_unit_r1 #(.REG_ADDR_WIDTH(5), .RD_PORTS(2), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .id_src(id_src), .id_src_used(id_src_used),
      .id_valid(id_valid), .id_regWrite(id_regWrite), .id_regToWrite(id_regToWrite),
      .id_memRead(id_memRead), .id_branch(id_branch), .id_redirect(id_redirect),
      .ex_busy(ex_busy), .stall(stall), .bubble_ex(bubble_ex), .flush_id(flush_id),
      .hold_ex(hold_ex), .forward_sel(forward_sel),
`ifdef ID_BRANCH_FWD_EN
      .id_forward_sel(id_forward_sel),
`endif
      .stall_count(stall_count)
   );

   hazard_forward_unit_r1 #(.REG_ADDR_WIDTH(5), .RD_PORTS(2), .CNT_WIDTH(4)) dut_small (
      .clk(clk), .rst(rst), .id_src(id_src), .id_src_used(id_src_used),
      .id_valid(id_valid), .id_regWrite(id_regWrite), .id_regToWrite(id_regToWrite),
      .id_memRead(id_memRead), .id_branch(id_branch), .id_redirect(id_redirect),
      .ex_busy(ex_busy), .stall(stall_s), .bubble_ex(bubble_s), .flush_id(flush_s),
      .hold_ex(hold_s), .forward_sel(fwd_s),
`ifdef ID_BRANCH_FWD_EN
      .id_forward_sel(id_fwd_s),
`endif
      .stall_count(count_s)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic we, input logic [4:0] rd,
                         input logic ld, input logic br, input logic rdr,
                         input logic [4:0] s0, input logic [4:0] s1,
                         input logic [1:0] used);
      id_valid      = v;
      id_regWrite   = we;
      id_regToWrite = rd;
      id_memRead    = ld;
      id_branch     = br;
      id_redirect   = rdr;
      id_src        = {s1, s0};
      id_src_used   = used;
   endtask

   task automatic idle();
      set_id(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
      ex_busy = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b0;
      tick();
      if ({stall, bubble_ex, flush_id, hold_ex, forward_sel} !== 8'h00) begin
         $display("FAIL reset_outputs: got %h want 00", {stall, bubble_ex, flush_id, hold_ex, forward_sel});
         n_fail++;
      end
      n_checks++;
      if (stall_count !== 16'd0) begin
         $display("FAIL reset_count: got %0d want 0", stall_count);
         n_fail++;
      end
      n_checks++;
      if ({stall_s, bubble_s, flush_s, hold_s, fwd_s, count_s} !== 12'h000) begin
         $display("FAIL reset_small: got %h want 000", {stall_s, bubble_s, flush_s, hold_s, fwd_s, count_s});
         n_fail++;
      end
      n_checks++;
      rst = 1'b1;
      #1;
   endtask

   task automatic test_load_use();
      do_reset();
      set_id(1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd1, 5'd0, 2'b01);  // lw $2,0($1)
      #1;
      if (stall !== 1'b0) begin
         $display("FAIL lu_first_nostall: got %b want 0", stall);
         n_fail++;
      end
      n_checks++;
      tick();
      set_id(1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 5'd2, 5'd4, 2'b11);  // add $3,$2,$4
      #1;
      if ({stall, bubble_ex, flush_id, hold_ex} !== 4'b1100) begin
         $display("FAIL lu_stall: got %b want 1100", {stall, bubble_ex, flush_id, hold_ex});
         n_fail++;
      end
      n_checks++;
      tick();
      if ({stall, bubble_ex, flush_id, hold_ex} !== 4'b0000 || stall_count !== 16'd1) begin
         $display("FAIL lu_release: got %b cnt %0d want 0000 cnt 1", {stall, bubble_ex, flush_id, hold_ex}, stall_count);
         n_fail++;
      end
      n_checks++;
      tick();
      idle();
      #1;
      if (forward_sel !== 4'b0010 || stall_count !== 16'd1) begin
         $display("FAIL lu_fwd_wb: got %b cnt %0d want 0010 cnt 1", forward_sel, stall_count);
         n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_alu_fwd();
      do_reset();
      set_id(1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd8, 5'd9, 2'b11);  // add $2,$8,$9
      tick();
      set_id(1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 5'd2, 5'd2, 2'b11);  // sub $5,$2,$2
      #1;
      if (stall !== 1'b0) begin
         $display("FAIL alu_nostall: got %b want 0", stall);
         n_fail++;
      end
      n_checks++;
      tick();
      idle();
      #1;
      if (forward_sel !== 4'b0101) begin
         $display("FAIL alu_fwd_mem: got %b want 0101", forward_sel);
         n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_wb_fwd();
      do_reset();
      set_id(1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd8, 5'd9, 2'b11);    // add $2
      tick();
      set_id(1'b1, 1'b1, 5'd10, 1'b0, 1'b0, 1'b0, 5'd11, 5'd12, 2'b11); // and $10
      tick();
      set_id(1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 5'd2, 5'd7, 2'b11);    // or $6,$2,$7
      tick();
      idle();
      #1;
      if (forward_sel !== 4'b0010) begin
         $display("FAIL wb_fwd: got %b want 0010", forward_sel);
         n_fail++;
      end
      n_checks++;
      // Both MEM and WB write $2: MEM must win.
      do_reset();
      set_id(1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd8, 5'd9, 2'b11);
      tick();
      set_id(1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd10, 5'd11, 2'b11);
      tick();
      set_id(1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 5'd2, 5'd2, 2'b11);
      tick();
      idle();
      #1;
      if (forward_sel !== 4'b0101) begin
         $display("FAIL mem_priority: got %b want 0101", forward_sel);
         n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_reg0();
      do_reset();
      set_id(1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd1, 5'd0, 2'b01);  // lw $0
      tick();
      set_id(1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 2'b11);  // reads $0 twice, as a branch too
      #1;
      if (stall !== 1'b0) begin
         $display("FAIL reg0_nostall: got %b want 0", stall);
         n_fail++;
      end
      n_checks++;
      tick();
      set_id(1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b11);
      tick();
      idle();
      #1;
      if (forward_sel !== 4'b0000) begin
         $display("FAIL reg0_fwd: got %b want 0000", forward_sel);
         n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_branch();
      do_reset();
      set_id(1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd8, 5'd9, 2'b11);  // add $2
      tick();
      set_id(1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd2, 5'd3, 2'b11);  // beq $2,$3 taken
      #1;
      if ({stall, bubble_ex, flush_id, hold_ex} !== 4'b1100) begin
         $display("FAIL br_stall1: got %b want 1100", {stall, bubble_ex, flush_id, hold_ex});
         n_fail++;
      end
      n_checks++;
      tick();
`ifdef ID_BRANCH_FWD_EN
      if ({stall, bubble_ex, flush_id, hold_ex} !== 4'b0010 || id_forward_sel !== 2'b01) begin
         $display("FAIL br_idfwd: got %b idfwd %b want 0010 idfwd 01", {stall, bubble_ex, flush_id, hold_ex}, id_forward_sel);
         n_fail++;
      end
      n_checks++;
      if (stall_count !== 16'd1) begin
         $display("FAIL br_count: got %0d want 1", stall_count);
         n_fail++;
      end
      n_checks++;
`else
      if ({stall, bubble_ex, flush_id, hold_ex} !== 4'b1100) begin
         $display("FAIL br_stall2: got %b want 1100", {stall, bubble_ex, flush_id, hold_ex});
         n_fail++;
      end
      n_checks++;
      tick();
      if ({stall, bubble_ex, flush_id, hold_ex} !== 4'b0010 || stall_count !== 16'd2) begin
         $display("FAIL br_flush: got %b cnt %0d want 0010 cnt 2", {stall, bubble_ex, flush_id, hold_ex}, stall_count);
         n_fail++;
      end
      n_checks++;
`endif
   endtask

   task automatic test_ex_busy();
      do_reset();
      set_id(1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd8, 5'd9, 2'b11);  // add $2
      tick();
      set_id(1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 5'd2, 5'd2, 2'b11);  // or $7,$2,$2
      tick();
      set_id(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 2'b00);  // j (redirect)
      ex_busy = 1'b1;
      #1;
      if ({stall, bubble_ex, flush_id, hold_ex} !== 4'b1001 || forward_sel !== 4'b0101) begin
         $display("FAIL busy_c1: got %b fwd %b want 1001 fwd 0101", {stall, bubble_ex, flush_id, hold_ex}, forward_sel);
         n_fail++;
      end
      n_checks++;
      tick();
      // MEM was loaded with a bubble, so the producer is now only visible in WB.
      if ({stall, bubble_ex, flush_id, hold_ex} !== 4'b1001 || forward_sel !== 4'b1010) begin
         $display("FAIL busy_c2: got %b fwd %b want 1001 fwd 1010", {stall, bubble_ex, flush_id, hold_ex}, forward_sel);
         n_fail++;
      end
      n_checks++;
      tick();
      if ({stall, bubble_ex, flush_id, hold_ex} !== 4'b1001 || forward_sel !== 4'b0000) begin
         $display("FAIL busy_c3: got %b fwd %b want 1001 fwd 0000", {stall, bubble_ex, flush_id, hold_ex}, forward_sel);
         n_fail++;
      end
      n_checks++;
      tick();
      ex_busy = 1'b0;
      #1;
      if ({stall, bubble_ex, flush_id, hold_ex} !== 4'b0010 || stall_count !== 16'd3) begin
         $display("FAIL busy_release: got %b cnt %0d want 0010 cnt 3", {stall, bubble_ex, flush_id, hold_ex}, stall_count);
         n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      set_id(1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd8, 5'd9, 2'b11);  // add $2
      tick();
      set_id(1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd2, 5'd3, 2'b11);  // beq $2,$3 not taken
      tick();
`ifndef ID_BRANCH_FWD_EN
      if ({stall, bubble_ex, stall_count} !== {2'b11, 16'd1}) begin
         $display("FAIL rst_mid_pre: got %b cnt %0d want 11 cnt 1", {stall, bubble_ex}, stall_count);
         n_fail++;
      end
      n_checks++;
`endif
      rst = 1'b0;
      #1;
      if ({stall, bubble_ex, flush_id, hold_ex, forward_sel} !== 8'h00 || stall_count !== 16'd0) begin
         $display("FAIL rst_mid_clear: got %h cnt %0d want 00 cnt 0", {stall, bubble_ex, flush_id, hold_ex, forward_sel}, stall_count);
         n_fail++;
      end
      n_checks++;
      rst = 1'b1;
      set_id(1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 5'd2, 5'd2, 2'b11);  // or $6,$2,$2
      #1;
      if (stall !== 1'b0) begin
         $display("FAIL rst_mid_nostall: got %b want 0", stall);
         n_fail++;
      end
      n_checks++;
      tick();
      idle();
      #1;
      if (forward_sel !== 4'b0000 || stall_count !== 16'd0) begin
         $display("FAIL rst_mid_stale: got fwd %b cnt %0d want 0000 cnt 0", forward_sel, stall_count);
         n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_saturation();
      do_reset();
      ex_busy = 1'b1;
      repeat (15) tick();
      if (count_s !== 4'd15) begin
         $display("FAIL sat_reach: got %0d want 15", count_s);
         n_fail++;
      end
      n_checks++;
      repeat (5) tick();
      if (count_s !== 4'd15) begin
         $display("FAIL sat_hold: got %0d want 15", count_s);
         n_fail++;
      end
      n_checks++;
      if (stall_count !== 16'd20) begin
         $display("FAIL sat_wide: got %0d want 20", stall_count);
         n_fail++;
      end
      n_checks++;
      ex_busy = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      idle();
      test_reset();
      test_load_use();
      test_alu_fwd();
      test_wb_fwd();
      test_reg0();
      test_branch();
      test_ex_busy();
      test_reset_mid_stall();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
